// File: rtl/iomem_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// iomem_bus_if
// Bundles the PicoSoC iomem master-side request/response signals and the
// per-slave fan-out signals handled by iomem_bus_ctrl.
//   m_*  : CPU side (request in, single-cycle completion out)
//   s_*  : peripheral side (one-hot request out, per-slave ready/rdata in)
// Modports:
//   slave  - the controller's view (it serves the CPU request)
//   master - the environment's view (CPU plus peripherals driving the inputs)
// -----------------------------------------------------------------------------
interface iomem_bus_if #(
  parameter int N_SLAVES = 4
);
  logic                       m_valid;
  logic                       m_ready;
  logic [3:0]                 m_wstrb;
  logic [31:0]                m_addr;
  logic [31:0]                m_wdata;
  logic [31:0]                m_rdata;
  logic [N_SLAVES-1:0]        s_valid;
  logic [3:0]                 s_wstrb;
  logic [31:0]                s_addr;
  logic [31:0]                s_wdata;
  logic [N_SLAVES-1:0]        s_ready;
  logic [32*N_SLAVES-1:0]     s_rdata;

  modport slave (
    input  m_valid, m_wstrb, m_addr, m_wdata, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata
  );

  modport master (
    output m_valid, m_wstrb, m_addr, m_wdata, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata
  );
endinterface

// File: rtl/iomem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// iomem_bus_ctrl
// Sequencing controller between the CPU iomem master port and up to N_SLAVES
// peripherals. Decodes addr[31:24], grants one slave, returns its ready/rdata
// as a one-cycle m_ready pulse, completes unmapped accesses with an error and
// latches the first error for software.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   bus (slave)   - m_* CPU request/response, s_* slave fan-out (see iomem_bus_if)
//   err_clr       - pulse, clears err_irq
//   err_irq       - level, set on any bus error
//   err_cause     - 01 unmapped, 10 timeout
//   err_addr      - address of the first error since the last clear
// Build option:
//   IOMEM_TIMEOUT_EN - when defined, a granted slave that withholds ready for
//   TIMEOUT_CYCLES cycles is abandoned with rdata 32'hFFFF_FFFF and cause 10.
// -----------------------------------------------------------------------------
module iomem_bus_ctrl #(
  parameter int                    N_SLAVES       = 4,
  parameter logic [8*N_SLAVES-1:0] SLAVE_IDS      = {8'h06, 8'h05, 8'h04, 8'h03},
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  iomem_bus_if.slave  bus,
  input  logic        err_clr,
  output logic        err_irq,
  output logic [1:0]  err_cause,
  output logic [31:0] err_addr
);

  if (N_SLAVES < 1 || N_SLAVES > 8) begin : g_bad_n_slaves
    $error("N_SLAVES must be in 1..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {IDLE, ACCESS, RESP, RESP_ERR, GAP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic                m_ready_q, m_ready_d;
  logic [31:0]         m_rdata_q, m_rdata_d;
  logic [N_SLAVES-1:0] s_valid_q, s_valid_d;
  logic [3:0]          s_wstrb_q, s_wstrb_d;
  logic [31:0]         s_addr_q, s_addr_d;
  logic [31:0]         s_wdata_q, s_wdata_d;
  logic                err_irq_q, err_irq_d;
  logic [1:0]          err_cause_q, err_cause_d;
  logic [31:0]         err_addr_q, err_addr_d;
`ifdef IOMEM_TIMEOUT_EN
  logic [15:0]         cnt_q, cnt_d;
`endif

  logic                hit;
  logic [2:0]          hit_idx;
  logic                ready_sel;
  logic [31:0]         rdata_sel;
  logic                err_set;
  logic [1:0]          err_new_cause;

  function automatic logic [N_SLAVES-1:0] onehot(input logic [2:0] idx);
    logic [N_SLAVES-1:0] v;
    v = '0;
    for (int i = 0; i < N_SLAVES; i++) v[i] = (idx == 3'(i));
    return v;
  endfunction

  // Scan from the top index down so the lowest matching slave wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (bus.m_addr[31:24] == SLAVE_IDS[8*i +: 8]) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  // Only the granted slave's ready/rdata are looked at.
  always_comb begin
    ready_sel = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == 3'(i)) begin
        ready_sel = bus.s_ready[i];
        rdata_sel = bus.s_rdata[32*i +: 32];
      end
    end
  end

  // Outputs are computed for the state being entered and then registered,
  // so s_ready never reaches m_ready combinationally.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    m_ready_d     = 1'b0;
    m_rdata_d     = '0;
    s_valid_d     = '0;
    s_wstrb_d     = s_wstrb_q;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    err_set       = 1'b0;
    err_new_cause = 2'b00;
`ifdef IOMEM_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.m_valid) begin
          s_wstrb_d = bus.m_wstrb;
          s_addr_d  = bus.m_addr;
          s_wdata_d = bus.m_wdata;
          if (hit) begin
            state_d   = ACCESS;
            sel_d     = hit_idx;
            s_valid_d = onehot(hit_idx);
`ifdef IOMEM_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end else begin
            state_d   = RESP_ERR;
            m_ready_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (ready_sel) begin
          state_d   = RESP;
          m_ready_d = 1'b1;
          m_rdata_d = rdata_sel;
`ifdef IOMEM_TIMEOUT_EN
        end else if (cnt_q == 16'(TIMEOUT_CYCLES)) begin
          state_d       = RESP;
          m_ready_d     = 1'b1;
          m_rdata_d     = 32'hFFFF_FFFF;
          err_set       = 1'b1;
          err_new_cause = 2'b10;
`endif
        end else begin
          s_valid_d = onehot(sel_q);
`ifdef IOMEM_TIMEOUT_EN
          cnt_d     = cnt_q + 16'd1;
`endif
        end
      end
      RESP: state_d = GAP;
      RESP_ERR: begin
        state_d       = GAP;
        err_set       = 1'b1;
        err_new_cause = 2'b01;
      end
      // Guard cycle: a request the CPU has not yet dropped is not re-issued.
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new error beats a simultaneous clear and then reloads cause/addr.
    err_irq_d   = err_irq_q;
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
    if (err_set) begin
      err_irq_d = 1'b1;
      if (!err_irq_q || err_clr) begin
        err_cause_d = err_new_cause;
        err_addr_d  = s_addr_q;
      end
    end else if (err_clr) begin
      err_irq_d = 1'b0;
    end
  end

  // ---- register stage ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      m_ready_q   <= 1'b0;
      m_rdata_q   <= '0;
      s_valid_q   <= '0;
      s_wstrb_q   <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      err_irq_q   <= 1'b0;
      err_cause_q <= '0;
      err_addr_q  <= '0;
`ifdef IOMEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      m_ready_q   <= m_ready_d;
      m_rdata_q   <= m_rdata_d;
      s_valid_q   <= s_valid_d;
      s_wstrb_q   <= s_wstrb_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      err_irq_q   <= err_irq_d;
      err_cause_q <= err_cause_d;
      err_addr_q  <= err_addr_d;
`ifdef IOMEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.m_ready = m_ready_q;
  assign bus.m_rdata = m_rdata_q;
  assign bus.s_valid = s_valid_q;
  assign bus.s_wstrb = s_wstrb_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_wdata = s_wdata_q;
  assign err_irq     = err_irq_q;
  assign err_cause   = err_cause_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_iomem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iomem_bus_ctrl
// Self-checking bench for iomem_bus_ctrl: directed scenarios followed by
// randomized transactions, each compared against a transaction-level model.
// Slave map used here: slave0=0x03, slave1=0x05, slave2=0x04, slave3=0x05
// (duplicate of slave1, so slave3 is never granted). TIMEOUT_CYCLES = 8.
// -----------------------------------------------------------------------------
module tb_iomem_bus_ctrl;
  localparam int N  = 4;
  localparam int TC = 8;
`ifdef IOMEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        err_clr;
  logic        err_irq;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;

  iomem_bus_if #(.N_SLAVES(N)) bus ();

  iomem_bus_ctrl #(
    .N_SLAVES       (N),
    .SLAVE_IDS      ({8'h05, 8'h04, 8'h05, 8'h03}),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_clr   (err_clr),
    .err_irq   (err_irq),
    .err_cause (err_cause),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model of the software-visible error status.
  logic        mdl_irq;
  logic [1:0]  mdl_cause;
  logic [31:0] mdl_addr;

  logic [7:0] ids [N] = '{8'h03, 8'h05, 8'h04, 8'h05};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int ref_sel(input logic [7:0] top);
    for (int i = 0; i < N; i++) if (ids[i] == top) return i;
    return -1;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_ready"}, 32'(bus.m_ready), 32'h0);
    chk({tag, "_m_rdata"}, bus.m_rdata, 32'h0);
    chk({tag, "_s_valid"}, 32'(bus.s_valid), 32'h0);
    chk({tag, "_s_wstrb"}, 32'(bus.s_wstrb), 32'h0);
    chk({tag, "_s_addr"}, bus.s_addr, 32'h0);
    chk({tag, "_s_wdata"}, bus.s_wdata, 32'h0);
    chk({tag, "_err_irq"}, 32'(err_irq), 32'h0);
    chk({tag, "_err_cause"}, 32'(err_cause), 32'h0);
    chk({tag, "_err_addr"}, err_addr, 32'h0);
  endtask

  // One CPU transaction. Called at a negedge; returns at the negedge of the
  // cycle where the next request may be accepted at the earliest.
  // k: cycle (counted from the request cycle 0) in which the granted slave
  // raises ready; hold: CPU keeps m_valid high through RESP and GAP;
  // clr_at_err: pulse err_clr in the cycle a miss raises its error.
  task automatic txn(input logic [31:0] addr, input logic [3:0] wstrb,
                     input logic [31:0] wdata, input int k, input logic [31:0] rdat,
                     input bit hold, input bit clr_at_err);
    int          idx, kk;
    bit          miss, to;
    logic [31:0] exp_data, exp_sv;
    idx  = ref_sel(addr[31:24]);
    miss = (idx < 0);
    to   = !miss && TO_EN && (k > TC + 1);
    kk   = miss ? 0 : (to ? TC + 1 : k);
    exp_data = miss ? 32'h0 : (to ? 32'hFFFF_FFFF : rdat);

    bus.m_valid = 1'b1;
    bus.m_addr  = addr;
    bus.m_wstrb = wstrb;
    bus.m_wdata = wdata;

    for (int c = 1; c <= kk + 3; c++) begin
      @(negedge clk);
      exp_sv = (!miss && c <= kk) ? (32'h1 << idx) : 32'h0;
      chk("s_valid", 32'(bus.s_valid), exp_sv);
      chk("m_ready", 32'(bus.m_ready), 32'(c == kk + 1));
      if (c == kk + 1) chk("m_rdata", bus.m_rdata, exp_data);
      if (c == 1) begin
        chk("s_addr", bus.s_addr, addr);
        chk("s_wstrb", 32'(bus.s_wstrb), 32'(wstrb));
        chk("s_wdata", bus.s_wdata, wdata);
      end
      // Slave side: noise on every slave, the granted one answers at cycle k.
      for (int j = 0; j < N; j++) begin
        bus.s_rdata[32*j +: 32] = $urandom;
        bus.s_ready[j] = ($urandom_range(0, 3) == 0);
      end
      if (!miss) begin
        bus.s_ready[idx] = (c == k);
        if (c == k) bus.s_rdata[32*idx +: 32] = rdat;
      end
      if (c == 1) begin
        if (!hold) bus.m_valid = 1'b0;
        if (clr_at_err && miss) err_clr = 1'b1;
      end
      if (c == 2) err_clr = 1'b0;
      if (c == kk + 3) begin
        if (miss || to) begin
          if (!mdl_irq || (clr_at_err && miss)) begin
            mdl_cause = miss ? 2'b01 : 2'b10;
            mdl_addr  = addr;
          end
          mdl_irq = 1'b1;
        end
        chk("err_irq", 32'(err_irq), 32'(mdl_irq));
        if (mdl_irq) begin
          chk("err_cause", 32'(err_cause), 32'(mdl_cause));
          chk("err_addr", err_addr, mdl_addr);
        end
        bus.m_valid = 1'b0;
        bus.s_ready = '0;
      end
    end
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    mdl_irq = 1'b0;
    chk("err_irq_clr", 32'(err_irq), 32'h0);
  endtask

  logic [31:0] r_addr;
  logic [7:0]  tops [7] = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09, 8'h00};

  initial begin
    reset = 1'b1;
    err_clr = 1'b0;
    bus.m_valid = 1'b0;
    bus.m_addr = '0;
    bus.m_wstrb = '0;
    bus.m_wdata = '0;
    bus.s_ready = '0;
    bus.s_rdata = '0;
    mdl_irq = 1'b0;
    mdl_cause = 2'b00;
    mdl_addr = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // Read from slave 0, ready three cycles after s_valid.
    txn(32'h0300_0010, 4'b0000, 32'h0, 4, 32'h1234_5678, 1'b0, 1'b0);
    // Write to slave 1 (0x05 is shared with slave 3; slave 1 wins).
    txn(32'h0500_0004, 4'b0011, 32'hAABB_CCDD, 2, 32'h0BAD_F00D, 1'b0, 1'b0);
    // Unmapped accesses: first error kept, then cleared.
    txn(32'h0900_0000, 4'b0000, 32'h0, 1, 32'h0, 1'b0, 1'b0);
    txn(32'h0A00_0000, 4'b0000, 32'h0, 1, 32'h0, 1'b0, 1'b0);
    clear_errors();

`ifdef IOMEM_TIMEOUT_EN
    // Slave 2 never answers, then answers exactly in the expiry cycle.
    txn(32'h0400_0020, 4'b0000, 32'h0, 1000, 32'h0, 1'b0, 1'b0);
    clear_errors();
    txn(32'h0400_0024, 4'b0000, 32'h0, TC + 1, 32'h5555_AAAA, 1'b0, 1'b0);
`endif

    // Back-to-back reads with m_valid held through RESP and GAP.
    txn(32'h0300_0100, 4'b0000, 32'h0, 1, 32'hCAFE_0001, 1'b1, 1'b0);
    txn(32'h0400_0200, 4'b0000, 32'h0, 2, 32'hCAFE_0002, 1'b1, 1'b0);

    // New miss while an error is latched, with err_clr in the same cycle.
    txn(32'h0700_0000, 4'b0000, 32'h0, 1, 32'h0, 1'b0, 1'b0);
    txn(32'h0800_0040, 4'b0000, 32'h0, 1, 32'h0, 1'b0, 1'b1);

    // Reset while in ACCESS: access dropped, everything back to reset values.
    bus.m_valid = 1'b1;
    bus.m_addr  = 32'h0300_0040;
    bus.m_wstrb = 4'b1111;
    bus.m_wdata = 32'h1111_2222;
    @(negedge clk);
    bus.m_valid = 1'b0;
    chk("rst_acc_s_valid", 32'(bus.s_valid), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mdl_irq = 1'b0;
    chk_reset_outputs("rst_acc");
    @(negedge clk);
    chk("rst_acc_no_ready", 32'(bus.m_ready), 32'h0);
    txn(32'h0300_0044, 4'b0000, 32'h0, 3, 32'h7777_8888, 1'b0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      r_addr = {tops[$urandom_range(0, 6)], 24'($urandom)};
      txn(r_addr,
          ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000,
          $urandom,
          TO_EN ? $urandom_range(1, 12) : $urandom_range(1, 8),
          $urandom,
          bit'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) clear_errors();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/iomem_bus_ctrl.md
# iomem_bus_ctrl

Sequencing controller for the PicoSoC peripheral bus (`iomem_*`). It sits between the CPU's single iomem master port and up to `N_SLAVES` peripherals such as GPIO and the video wrapper. Each transaction runs through a registered state machine that:
- decodes the address and grants exactly one slave;
- returns that slave's ready and read data;
- completes unmapped or hung accesses with an error instead of stalling the CPU;
- latches error status for software.

## Interface
- `N_SLAVES`, 4, number of slave ports (1..8).
- `SLAVE_IDS`, {8'h06,8'h05,8'h04,8'h03}, concatenated 8-bit `addr[31:24]` match values; slave i uses bits [8i+7:8i].
- `TIMEOUT_CYCLES`, 255, maximum cycles a granted slave may hold off ready (1..65535).
- `clk` in 1: system clock (100 MHz).
- `reset` in 1: synchronous, active-high reset.
- `m_valid` in 1: CPU request.
- `m_ready` out 1: one-cycle completion pulse.
- `m_wstrb` in 4: byte write strobes; 0 means read.
- `m_addr` in 32: address.
- `m_wdata` in 32: write data.
- `m_rdata` out 32: read data, valid while `m_ready`=1.
- `s_valid` out N_SLAVES: one-hot request to the granted slave.
- `s_wstrb` / `s_addr` / `s_wdata` out 4/32/32: registered copies of the CPU request, broadcast to all slaves.
- `s_ready` in N_SLAVES: per-slave ready.
- `s_rdata` in 32*N_SLAVES: per-slave read data; slave i uses bits [32i+31:32i].
- `err_clr` in 1: pulse that clears error status.
- `err_irq` out 1: level, set on any bus error.
- `err_cause` out 2: 01 = unmapped, 10 = timeout.
- `err_addr` out 32: address of the first error since the last clear.

## Operation
States:
- **IDLE:**
  - On `m_valid`, register wstrb, addr and wdata.
  - Decode `m_addr[31:24]` against `SLAVE_IDS`; the lowest index wins on duplicate IDs.
  - Hit → ACCESS. Miss → RESP_ERR.
- **ACCESS:**
  - `s_valid[sel]`=1; all other `s_valid` bits are 0.
  - On `s_ready[sel]`=1, capture `s_rdata[sel]` → RESP.
  - `s_ready` from non-selected slaves is ignored.
- **RESP:** `m_ready`=1, `m_rdata`=captured data, `s_valid`=0 → GAP.
- **RESP_ERR:** `m_ready`=1, `m_rdata`=32'h0000_0000. Set error status with cause 01 → GAP.
- **GAP:** one guard cycle; `m_valid` is ignored → IDLE. This prevents re-issuing a request the CPU has not yet dropped.

Error status:
- `err_irq` sets on any error and stays high until `err_clr`.
- `err_addr` and `err_cause` load only when `err_irq` is 0, so the first error is kept.
- `err_clr` in the same cycle as a new error: the new error wins; `err_irq` stays 1 and `err_addr`/`err_cause` reload.

Writes pass through unchanged. Byte lanes are the slave's responsibility.

## Timing
- Reset values: `m_ready`=0, `m_rdata`=0, `s_valid`=0, `s_wstrb`=0, `s_addr`=0, `s_wdata`=0, `err_irq`=0, `err_cause`=0, `err_addr`=0. State = IDLE.
- `reset` mid-transaction drops the access: no `m_ready` is issued, and `s_valid` is 0 the cycle after reset.
- Hit latency: `m_valid` sampled at cycle 0 → `s_valid` high at cycle 1 → `s_ready` at cycle k≥1 → `m_ready` at cycle k+1.
- Back-to-back rate: the next request is accepted at cycle k+3 at the earliest.
- Miss latency: `m_ready` at cycle 1; the error flags are visible at cycle 2.
- All outputs are registered. No combinational path exists from `s_ready` to `m_ready`.

## Configuration
`IOMEM_TIMEOUT_EN`:
- **Defined:**
  - A 16-bit counter clears on entry to ACCESS and increments each cycle in ACCESS.
  - When the counter reaches `TIMEOUT_CYCLES` with no `s_ready[sel]`: drop `s_valid`, go to RESP with `m_rdata`=32'hFFFF_FFFF, and set error status with cause 10.
  - If `s_ready[sel]` arrives in the expiry cycle, ready wins and no error is raised.
- **Undefined:** no counter. ACCESS waits indefinitely, and cause 10 never occurs.

## Test plan
- Read at 0x0300_0010, slave 0 returns ready 3 cycles after `s_valid` with data 0x1234_5678 → `s_valid`=4'b0001; `m_ready` fires one cycle after `s_ready` with `m_rdata`=0x1234_5678; `err_irq`=0.
- Write wstrb=4'b0011 to 0x0500_0004 with data 0xAABB_CCDD → `s_valid`=4'b0010; `s_wstrb`=4'b0011, `s_addr`=0x0500_0004 and `s_wdata`=0xAABB_CCDD while `s_valid` is high.
- Read at 0x0900_0000 (unmapped) → `m_ready` at cycle 1 with data 0; `err_irq`=1, `err_cause`=01, `err_addr`=0x0900_0000. A second miss at 0x0A00_0000 leaves `err_addr` unchanged. `err_clr` → `err_irq`=0.
- With `IOMEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, slave 2 never ready → `m_ready` at cycle 10 (`s_valid` at cycle 1, expiry 8 cycles later, response the cycle after) with data 0xFFFF_FFFF; `err_cause`=10. Repeat with `s_ready` in the expiry cycle → normal data and no error.
- Two back-to-back reads with `m_valid` held high one extra cycle → exactly two `s_valid` assertions; the GAP cycle ignores the held request.
- `reset` asserted in ACCESS → no `m_ready`; all outputs are at reset values on the next cycle; the next request completes normally.
